// File: rtl/spell_mem_arbiter.sv
`timescale 1ns/1ps
// spell_mem_arbiter: two-requester arbiter for the single-slave memory-mapped
// IO bus. m0 is the CPU core, m1 is the debug/host port. Each access goes
// IDLE -> ACCESS -> DONE, so at least two select-low cycles separate
// transactions and edge-qualified slaves see each write exactly once.
// A hung access is forced to finish after TIMEOUT cycles in ACCESS.
module spell_mem_arbiter #(
  parameter bit ROUND_ROBIN = 1'b1,
  parameter int TIMEOUT     = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       m0_select,
  input  logic [7:0] m0_addr,
  input  logic [7:0] m0_data_in,
  input  logic       m0_write,
  output logic [7:0] m0_data_out,
  output logic       m0_data_ready,
  input  logic       m1_select,
  input  logic [7:0] m1_addr,
  input  logic [7:0] m1_data_in,
  input  logic       m1_write,
  output logic [7:0] m1_data_out,
  output logic       m1_data_ready,
  output logic       s_select,
  output logic [7:0] s_addr,
  output logic [7:0] s_data_in,
  output logic       s_write,
  input  logic [7:0] s_data_out,
  input  logic       s_data_ready,
  output logic       timeout_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Last counter value reached in ACCESS before the access is forced to end.
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  state_t     state, state_nxt;
  logic       last_grant, last_grant_nxt;
  logic       grant, grant_nxt;
  logic [7:0] cnt, cnt_nxt;

  logic       s_select_nxt, s_write_nxt;
  logic [7:0] s_addr_nxt, s_data_in_nxt;
  logic [7:0] m0_data_out_nxt, m1_data_out_nxt;
  logic       m0_data_ready_nxt, m1_data_ready_nxt, timeout_err_nxt;

  logic       any_req, pick, timeout_hit, complete;
  logic [7:0] complete_data;

  // Choose which requester would win if arbitration happened this cycle.
  always_comb begin
    any_req = m0_select | m1_select;
    if (m0_select && m1_select) begin
      pick = ROUND_ROBIN ? ~last_grant : 1'b0;
    end else begin
      pick = m1_select;
    end
  end

  // Decide whether the current access ends and what read data it returns;
  // a ready in the threshold cycle counts as a normal completion.
  always_comb begin
    timeout_hit = (cnt == TIMEOUT_LAST);
    complete    = (state == ACCESS) && (s_data_ready || timeout_hit);
    if (s_write) begin
      complete_data = 8'h00;
    end else if (s_data_ready) begin
      complete_data = s_data_out;
    end else begin
      complete_data = 8'hff;
    end
  end

  // State register plus every registered output, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      last_grant    <= 1'b1;
      grant         <= 1'b0;
      cnt           <= 8'd0;
      s_select      <= 1'b0;
      s_addr        <= 8'd0;
      s_data_in     <= 8'd0;
      s_write       <= 1'b0;
      m0_data_out   <= 8'd0;
      m1_data_out   <= 8'd0;
      m0_data_ready <= 1'b0;
      m1_data_ready <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      state         <= state_nxt;
      last_grant    <= last_grant_nxt;
      grant         <= grant_nxt;
      cnt           <= cnt_nxt;
      s_select      <= s_select_nxt;
      s_addr        <= s_addr_nxt;
      s_data_in     <= s_data_in_nxt;
      s_write       <= s_write_nxt;
      m0_data_out   <= m0_data_out_nxt;
      m1_data_out   <= m1_data_out_nxt;
      m0_data_ready <= m0_data_ready_nxt;
      m1_data_ready <= m1_data_ready_nxt;
      timeout_err   <= timeout_err_nxt;
    end
  end

  // Next-state logic: DONE always lasts one cycle and never arbitrates.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = ACCESS;
      ACCESS:  if (complete) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs; completion pulses default low.
  always_comb begin
    last_grant_nxt    = last_grant;
    grant_nxt         = grant;
    cnt_nxt           = cnt;
    s_select_nxt      = s_select;
    s_addr_nxt        = s_addr;
    s_data_in_nxt     = s_data_in;
    s_write_nxt       = s_write;
    m0_data_out_nxt   = m0_data_out;
    m1_data_out_nxt   = m1_data_out;
    m0_data_ready_nxt = 1'b0;
    m1_data_ready_nxt = 1'b0;
    timeout_err_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) begin
          s_addr_nxt     = pick ? m1_addr : m0_addr;
          s_data_in_nxt  = pick ? m1_data_in : m0_data_in;
          s_write_nxt    = pick ? m1_write : m0_write;
          s_select_nxt   = 1'b1;
          last_grant_nxt = pick;
          grant_nxt      = pick;
          cnt_nxt        = 8'd0;
        end
      end
      ACCESS: begin
        if (complete) begin
          s_select_nxt    = 1'b0;
          s_write_nxt     = 1'b0;
          timeout_err_nxt = ~s_data_ready;
          if (grant) begin
            m1_data_out_nxt   = complete_data;
            m1_data_ready_nxt = 1'b1;
          end else begin
            m0_data_out_nxt   = complete_data;
            m0_data_ready_nxt = 1'b1;
          end
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_spell_mem_arbiter.sv
`timescale 1ns/1ps
// Bench for spell_mem_arbiter. Instance A is round-robin with TIMEOUT=8 and a
// slave that can hang and toggles io_out on edge-qualified writes; instance B
// is fixed-priority with TIMEOUT=2 so its zero-wait ready lands on the
// timeout threshold cycle. Completions are logged by monitors and compared
// against an expected queue filled when stimulus is driven.
module tb_spell_mem_arbiter;

  typedef struct packed {
    logic [31:0] cyc;
    logic        both;
    logic        m;
    logic        to;
    logic [7:0]  data;
  } cpl_t;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       rst_q = 1'b0;
  int         cyc   = 0;
  int         total = 0;
  int         bad   = 0;

  logic       sel  [2][2];
  logic       wr   [2][2];
  logic [7:0] addr [2][2];
  logic [7:0] din  [2][2];

  logic [7:0] a_dout0, a_dout1, a_saddr, a_sdin, a_sdout;
  logic       a_rdy0, a_rdy1, a_ssel, a_swr, a_srdy, a_to;
  logic [7:0] b_dout0, b_dout1, b_saddr, b_sdin, b_sdout;
  logic       b_rdy0, b_rdy1, b_ssel, b_swr, b_srdy, b_to;

  logic       a_hang = 1'b0;
  logic       a_past_wr = 1'b0;
  logic       io_out = 1'b0;
  int         toggles = 0;

  cpl_t       act_a[$], act_b[$], exp_a[$], exp_b[$];
  int         gap_a = 0, gap_b = 0, low_a = 99, low_b = 99;
  int         orphan_a = 0, orphan_b = 0, cross_a = 0, cross_b = 0;
  logic       prev_a = 1'b0, prev_b = 1'b0;
  logic [7:0] pd_a0 = 8'd0, pd_a1 = 8'd0, pd_b0 = 8'd0, pd_b1 = 8'd0;

  spell_mem_arbiter #(.ROUND_ROBIN(1'b1), .TIMEOUT(8)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .m0_select(sel[0][0]), .m0_addr(addr[0][0]), .m0_data_in(din[0][0]), .m0_write(wr[0][0]),
    .m0_data_out(a_dout0), .m0_data_ready(a_rdy0),
    .m1_select(sel[0][1]), .m1_addr(addr[0][1]), .m1_data_in(din[0][1]), .m1_write(wr[0][1]),
    .m1_data_out(a_dout1), .m1_data_ready(a_rdy1),
    .s_select(a_ssel), .s_addr(a_saddr), .s_data_in(a_sdin), .s_write(a_swr),
    .s_data_out(a_sdout), .s_data_ready(a_srdy), .timeout_err(a_to)
  );

  spell_mem_arbiter #(.ROUND_ROBIN(1'b0), .TIMEOUT(2)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .m0_select(sel[1][0]), .m0_addr(addr[1][0]), .m0_data_in(din[1][0]), .m0_write(wr[1][0]),
    .m0_data_out(b_dout0), .m0_data_ready(b_rdy0),
    .m1_select(sel[1][1]), .m1_addr(addr[1][1]), .m1_data_in(din[1][1]), .m1_write(wr[1][1]),
    .m1_data_out(b_dout1), .m1_data_ready(b_rdy1),
    .s_select(b_ssel), .s_addr(b_saddr), .s_data_in(b_sdin), .s_write(b_swr),
    .s_data_out(b_sdout), .s_data_ready(b_srdy), .timeout_err(b_to)
  );

  always #5 clk = ~clk;

  // Cycle counter and a registered copy of reset for the negedge monitors.
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst_n;
  end

  // Slave A: ready one cycle after select unless hung; io_out toggles once per write.
  always @(posedge clk) begin
    a_srdy    <= rst_n && a_ssel && !a_srdy && !a_hang;
    a_sdout   <= a_saddr ^ 8'h6c;
    a_past_wr <= a_ssel && a_swr;
    if (a_ssel && a_swr && !a_past_wr && a_saddr == 8'h36 && a_sdin[0]) begin
      io_out  <= ~io_out;
      toggles <= toggles + 1;
    end
  end

  // Slave B: always zero-wait.
  always @(posedge clk) begin
    b_srdy  <= rst_n && b_ssel && !b_srdy;
    b_sdout <= b_saddr ^ 8'h6c;
  end

  // Monitor A: log completions, select-low gaps, orphan timeouts, stray data changes.
  always @(negedge clk) begin : mon_a
    cpl_t c;
    if (a_rdy0 || a_rdy1) begin
      c.cyc = 32'(cyc); c.both = a_rdy0 && a_rdy1; c.m = a_rdy1;
      c.to = a_to; c.data = a_rdy1 ? a_dout1 : a_dout0;
      act_a.push_back(c);
    end
    if (a_to && !(a_rdy0 || a_rdy1)) orphan_a++;
    if (!rst_q) low_a = 99;
    else if (a_ssel) begin
      if (!prev_a && low_a < 2) gap_a++;
      low_a = 0;
    end else low_a++;
    prev_a = a_ssel;
    if (rst_q && !a_rdy0 && a_dout0 !== pd_a0) cross_a++;
    if (rst_q && !a_rdy1 && a_dout1 !== pd_a1) cross_a++;
    pd_a0 = a_dout0; pd_a1 = a_dout1;
  end

  // Monitor B: same bookkeeping for the fixed-priority instance.
  always @(negedge clk) begin : mon_b
    cpl_t c;
    if (b_rdy0 || b_rdy1) begin
      c.cyc = 32'(cyc); c.both = b_rdy0 && b_rdy1; c.m = b_rdy1;
      c.to = b_to; c.data = b_rdy1 ? b_dout1 : b_dout0;
      act_b.push_back(c);
    end
    if (b_to && !(b_rdy0 || b_rdy1)) orphan_b++;
    if (!rst_q) low_b = 99;
    else if (b_ssel) begin
      if (!prev_b && low_b < 2) gap_b++;
      low_b = 0;
    end else low_b++;
    prev_b = b_ssel;
    if (rst_q && !b_rdy0 && b_dout0 !== pd_b0) cross_b++;
    if (rst_q && !b_rdy1 && b_dout1 !== pd_b1) cross_b++;
    pd_b0 = b_dout0; pd_b1 = b_dout1;
  end

  function automatic cpl_t mk(input logic m, input logic to, input logic [7:0] data);
    cpl_t c;
    c.cyc = 32'd0; c.both = 1'b0; c.m = m; c.to = to; c.data = data;
    return c;
  endfunction

  function automatic logic get_rdy(input int d, input int m);
    if (d == 0) return (m == 0) ? a_rdy0 : a_rdy1;
    return (m == 0) ? b_rdy0 : b_rdy1;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    a_hang = 1'b0;
    for (int d = 0; d < 2; d++) for (int m = 0; m < 2; m++) sel[d][m] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    act_a.delete(); act_b.delete(); exp_a.delete(); exp_b.delete();
    gap_a = 0; gap_b = 0; orphan_a = 0; orphan_b = 0; cross_a = 0; cross_b = 0;
    rst_n = 1'b1;
  endtask

  // Requester obeying the contract: hold select through ntx completions, then drop.
  task automatic hold_req(input int d, input int m, input logic [7:0] a, input logic [7:0] wd,
                          input logic w, input int ntx);
    int seen = 0;
    int guard = 0;
    sel[d][m] = 1'b1; addr[d][m] = a; din[d][m] = wd; wr[d][m] = w;
    while (seen < ntx && guard < 200) begin
      @(negedge clk);
      guard++;
      if (get_rdy(d, m)) seen++;
    end
    sel[d][m] = 1'b0;
    total++;
    if (seen < ntx) begin
      bad++;
      $display("[TB] FAIL hold_req_d%0d_m%0d: got %0d completions want %0d", d, m, seen, ntx);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++;
    if ({a_ssel, a_swr, a_saddr, a_sdin, a_rdy0, a_rdy1, a_dout0, a_dout1, a_to} !== 43'd0) begin
      bad++;
      $display("[TB] FAIL reset_a: got %h want 0",
               {a_ssel, a_swr, a_saddr, a_sdin, a_rdy0, a_rdy1, a_dout0, a_dout1, a_to});
    end
    total++;
    if ({b_ssel, b_swr, b_saddr, b_sdin, b_rdy0, b_rdy1, b_dout0, b_dout1, b_to} !== 43'd0) begin
      bad++;
      $display("[TB] FAIL reset_b: got %h want 0",
               {b_ssel, b_swr, b_saddr, b_sdin, b_rdy0, b_rdy1, b_dout0, b_dout1, b_to});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single_read();
    logic [5:0] sel_pat = 6'b000110;
    cpl_t got, want;
    exp_a.push_back(mk(1'b0, 1'b0, 8'h5a));
    sel[0][0] = 1'b1; addr[0][0] = 8'h36; din[0][0] = 8'h00; wr[0][0] = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      total++;
      if (a_ssel !== sel_pat[k]) begin
        bad++; $display("[TB] FAIL single_s_select_c%0d: got %b want %b", k, a_ssel, sel_pat[k]);
      end
      total++;
      if (a_rdy0 !== 1'(k == 3)) begin
        bad++; $display("[TB] FAIL single_m0_ready_c%0d: got %b want %b", k, a_rdy0, k == 3);
      end
      total++;
      if ({a_rdy1, a_dout1} !== 9'd0) begin
        bad++; $display("[TB] FAIL single_m1_quiet_c%0d: got %h want 0", k, {a_rdy1, a_dout1});
      end
      if (k == 1) begin
        total++;
        if (a_saddr !== 8'h36) begin
          bad++; $display("[TB] FAIL single_s_addr: got %h want 36", a_saddr);
        end
      end
      if (a_rdy0) sel[0][0] = 1'b0;
    end
    for (int g = 0; g < 50 && act_a.size() < exp_a.size(); g++) @(posedge clk);
    total++;
    if (act_a.size() != exp_a.size()) begin
      bad++; $display("[TB] FAIL single_count: got %0d want %0d", act_a.size(), exp_a.size());
    end
    while (exp_a.size() > 0 && act_a.size() > 0) begin
      want = exp_a.pop_front(); got = act_a.pop_front();
      total++;
      if ({got.both, got.m, got.to, got.data} !== {want.both, want.m, want.to, want.data}) begin
        bad++; $display("[TB] FAIL single_cpl: got m=%0d to=%0d data=%h want m=%0d to=%0d data=%h",
                        got.m, got.to, got.data, want.m, want.to, want.data);
      end
    end
    exp_a.delete(); act_a.delete();
  endtask

  task automatic test_round_robin();
    cpl_t got, want;
    int n = 0;
    logic [31:0] prev_cyc = 32'd0;
    do_reset();
    for (int i = 0; i < 2; i++) begin
      exp_a.push_back(mk(1'b0, 1'b0, 8'h7c));
      exp_a.push_back(mk(1'b1, 1'b0, 8'h4c));
    end
    fork
      hold_req(0, 0, 8'h10, 8'h00, 1'b0, 2);
      hold_req(0, 1, 8'h20, 8'h00, 1'b0, 2);
    join
    for (int g = 0; g < 50 && act_a.size() < exp_a.size(); g++) @(posedge clk);
    total++;
    if (act_a.size() != exp_a.size()) begin
      bad++; $display("[TB] FAIL rr_count: got %0d want %0d", act_a.size(), exp_a.size());
    end
    while (exp_a.size() > 0 && act_a.size() > 0) begin
      want = exp_a.pop_front(); got = act_a.pop_front();
      total++;
      if ({got.both, got.m, got.to, got.data} !== {want.both, want.m, want.to, want.data}) begin
        bad++; $display("[TB] FAIL rr_cpl%0d: got m=%0d to=%0d data=%h both=%0d want m=%0d to=%0d data=%h",
                        n, got.m, got.to, got.data, got.both, want.m, want.to, want.data);
      end
      if (n > 0) begin
        total++;
        if (got.cyc - prev_cyc != 32'd4) begin
          bad++; $display("[TB] FAIL rr_spacing%0d: got %0d want 4", n, got.cyc - prev_cyc);
        end
      end
      prev_cyc = got.cyc; n++;
    end
    total++;
    if (gap_a != 0 || cross_a != 0) begin
      bad++; $display("[TB] FAIL rr_gap_cross: got gap=%0d cross=%0d want 0 0", gap_a, cross_a);
    end
    exp_a.delete(); act_a.delete();
  endtask

  task automatic test_fixed_priority();
    cpl_t got, want;
    int n = 0;
    logic [31:0] prev_cyc = 32'd0;
    do_reset();
    for (int i = 0; i < 3; i++) exp_b.push_back(mk(1'b0, 1'b0, 8'h5c));
    exp_b.push_back(mk(1'b1, 1'b0, 8'h28));
    fork
      hold_req(1, 0, 8'h30, 8'h00, 1'b0, 3);
      hold_req(1, 1, 8'h44, 8'h00, 1'b0, 1);
    join
    for (int g = 0; g < 50 && act_b.size() < exp_b.size(); g++) @(posedge clk);
    total++;
    if (act_b.size() != exp_b.size()) begin
      bad++; $display("[TB] FAIL fp_count: got %0d want %0d", act_b.size(), exp_b.size());
    end
    while (exp_b.size() > 0 && act_b.size() > 0) begin
      want = exp_b.pop_front(); got = act_b.pop_front();
      total++;
      if ({got.both, got.m, got.to, got.data} !== {want.both, want.m, want.to, want.data}) begin
        bad++; $display("[TB] FAIL fp_cpl%0d: got m=%0d to=%0d data=%h both=%0d want m=%0d to=%0d data=%h",
                        n, got.m, got.to, got.data, got.both, want.m, want.to, want.data);
      end
      if (n > 0) begin
        total++;
        if (got.cyc - prev_cyc != 32'd4) begin
          bad++; $display("[TB] FAIL fp_spacing%0d: got %0d want 4", n, got.cyc - prev_cyc);
        end
      end
      prev_cyc = got.cyc; n++;
    end
    total++;
    if (gap_b != 0 || cross_b != 0 || orphan_b != 0) begin
      bad++; $display("[TB] FAIL fp_gap_cross_orphan: got %0d %0d %0d want 0 0 0", gap_b, cross_b, orphan_b);
    end
    exp_b.delete(); act_b.delete();
  endtask

  task automatic test_back_to_back();
    cpl_t got, want;
    int n = 0;
    logic io0;
    logic [31:0] prev_cyc = 32'd0;
    do_reset();
    io0 = io_out;
    toggles = 0;
    exp_a.push_back(mk(1'b0, 1'b0, 8'h5a));
    exp_a.push_back(mk(1'b0, 1'b0, 8'h00));
    exp_a.push_back(mk(1'b0, 1'b0, 8'h00));
    hold_req(0, 0, 8'h36, 8'h00, 1'b0, 1);
    hold_req(0, 0, 8'h36, 8'h01, 1'b1, 2);
    for (int g = 0; g < 50 && act_a.size() < exp_a.size(); g++) @(posedge clk);
    total++;
    if (act_a.size() != exp_a.size()) begin
      bad++; $display("[TB] FAIL b2b_count: got %0d want %0d", act_a.size(), exp_a.size());
    end
    while (exp_a.size() > 0 && act_a.size() > 0) begin
      want = exp_a.pop_front(); got = act_a.pop_front();
      total++;
      if ({got.both, got.m, got.to, got.data} !== {want.both, want.m, want.to, want.data}) begin
        bad++; $display("[TB] FAIL b2b_cpl%0d: got m=%0d to=%0d data=%h want m=%0d to=%0d data=%h",
                        n, got.m, got.to, got.data, want.m, want.to, want.data);
      end
      if (n > 0) begin
        total++;
        if (got.cyc - prev_cyc != 32'd4) begin
          bad++; $display("[TB] FAIL b2b_spacing%0d: got %0d want 4", n, got.cyc - prev_cyc);
        end
      end
      prev_cyc = got.cyc; n++;
    end
    total++;
    if (toggles != 2 || io_out !== io0) begin
      bad++; $display("[TB] FAIL b2b_io_out: got toggles=%0d io=%b want toggles=2 io=%b", toggles, io_out, io0);
    end
    exp_a.delete(); act_a.delete();
  endtask

  task automatic test_timeout();
    cpl_t got, want;
    int n = 0;
    int c_req;
    do_reset();
    a_hang = 1'b1;
    c_req = cyc;
    exp_a.push_back(mk(1'b1, 1'b1, 8'hff));
    exp_a.push_back(mk(1'b0, 1'b0, 8'h7e));
    hold_req(0, 1, 8'h40, 8'h00, 1'b0, 1);
    a_hang = 1'b0;
    hold_req(0, 0, 8'h12, 8'h00, 1'b0, 1);
    for (int g = 0; g < 50 && act_a.size() < exp_a.size(); g++) @(posedge clk);
    total++;
    if (act_a.size() != exp_a.size()) begin
      bad++; $display("[TB] FAIL to_count: got %0d want %0d", act_a.size(), exp_a.size());
    end
    while (exp_a.size() > 0 && act_a.size() > 0) begin
      want = exp_a.pop_front(); got = act_a.pop_front();
      total++;
      if ({got.both, got.m, got.to, got.data} !== {want.both, want.m, want.to, want.data}) begin
        bad++; $display("[TB] FAIL to_cpl%0d: got m=%0d to=%0d data=%h want m=%0d to=%0d data=%h",
                        n, got.m, got.to, got.data, want.m, want.to, want.data);
      end
      if (n == 0) begin
        total++;
        if (got.cyc - 32'(c_req) != 32'd9) begin
          bad++; $display("[TB] FAIL to_latency: got %0d want 9", got.cyc - 32'(c_req));
        end
      end
      n++;
    end
    total++;
    if (orphan_a != 0 || cross_a != 0 || gap_a != 0) begin
      bad++; $display("[TB] FAIL to_orphan_cross_gap: got %0d %0d %0d want 0 0 0", orphan_a, cross_a, gap_a);
    end
    exp_a.delete(); act_a.delete();
  endtask

  task automatic test_reset_mid_access();
    cpl_t got, want;
    a_hang = 1'b1;
    sel[0][0] = 1'b1; addr[0][0] = 8'h21; din[0][0] = 8'h00; wr[0][0] = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (a_ssel !== 1'b1) begin
      bad++; $display("[TB] FAIL rst_mid_in_access: got %b want 1", a_ssel);
    end
    rst_n = 1'b0;
    @(negedge clk);
    total++;
    if ({a_ssel, a_swr, a_saddr, a_sdin, a_rdy0, a_rdy1, a_dout0, a_dout1, a_to} !== 43'd0) begin
      bad++;
      $display("[TB] FAIL rst_mid_outputs: got %h want 0",
               {a_ssel, a_swr, a_saddr, a_sdin, a_rdy0, a_rdy1, a_dout0, a_dout1, a_to});
    end
    total++;
    if (act_a.size() != 0) begin
      bad++; $display("[TB] FAIL rst_mid_no_ready: got %0d completions want 0", act_a.size());
    end
    rst_n = 1'b1;
    a_hang = 1'b0;
    exp_a.push_back(mk(1'b0, 1'b0, 8'h4d));
    @(negedge clk);
    total++;
    if ({a_ssel, a_saddr} !== {1'b1, 8'h21}) begin
      bad++; $display("[TB] FAIL rst_mid_regrant: got %h want 121", {a_ssel, a_saddr});
    end
    for (int g = 0; g < 40 && !a_rdy0; g++) @(negedge clk);
    sel[0][0] = 1'b0;
    for (int g = 0; g < 50 && act_a.size() < exp_a.size(); g++) @(posedge clk);
    repeat (3) @(posedge clk);
    total++;
    if (act_a.size() != exp_a.size()) begin
      bad++; $display("[TB] FAIL rst_mid_count: got %0d want %0d", act_a.size(), exp_a.size());
    end
    while (exp_a.size() > 0 && act_a.size() > 0) begin
      want = exp_a.pop_front(); got = act_a.pop_front();
      total++;
      if ({got.both, got.m, got.to, got.data} !== {want.both, want.m, want.to, want.data}) begin
        bad++; $display("[TB] FAIL rst_mid_cpl: got m=%0d to=%0d data=%h want m=%0d to=%0d data=%h",
                        got.m, got.to, got.data, want.m, want.to, want.data);
      end
    end
    exp_a.delete(); act_a.delete();
  endtask

  // Safety net so the run always ends even if a wait loop misbehaves.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      for (int m = 0; m < 2; m++) begin
        sel[d][m] = 1'b0; wr[d][m] = 1'b0; addr[d][m] = 8'd0; din[d][m] = 8'd0;
      end
    end
    test_reset();
    test_single_read();
    test_round_robin();
    test_fixed_priority();
    test_back_to_back();
    test_timeout();
    test_reset_mid_access();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
